bcd_serial_add_ctrl: RTL

//   Sequencer that runs a multi-digit packed-BCD addition through one shared

---
 rtl/bcd_serial_add_ctrl_if.sv | 43 ++++
 rtl/bcd_serial_add_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl_if.sv
// ============================================================================
//  Module      : bcd_serial_add_ctrl_if
//  Description : Requester handshake and shared single-digit adder bus
//                for the serial packed-BCD addition sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    // Requester side
    logic                  start;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  C_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   S;
    logic                  C_out;
    logic                  err;

    // Shared single-digit adder side
    logic [3:0]            add_a;
    logic [3:0]            add_b;
    logic                  add_cin;
    logic [3:0]            add_s;
    logic                  add_cout;

    // Environment: requester plus the external adder
    modport master (
        output start, A, B, C_in, add_s, add_cout,
        input  busy, done, S, C_out, err, add_a, add_b, add_cin
    );

    // Sequencer
    modport slave (
        input  start, A, B, C_in, add_s, add_cout,
        output busy, done, S, C_out, err, add_a, add_b, add_cin
    );
endinterface

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
//  Module      : bcd_serial_add_ctrl
//  Description : Runs a multi-digit packed-BCD add through one shared
//                single-digit BCD adder, one digit per clock, LSD first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input wire                   clk,
    input wire                   rst,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_add  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_err;
    logic [IDX_W-1:0] r_idx;

    logic             w_last_step;
    logic             w_bad_operand;

    // Any nibble above 9 makes the operand non-BCD.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign w_last_step   = (r_idx == c_last_idx);
    assign w_bad_operand = has_bad_digit(bus.A) | has_bad_digit(bus.B);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (bus.start) begin
                    w_next_state = c_add;
                end
            end
            c_add: begin
                if (w_last_step) begin
                    w_next_state = c_done;
                end
            end
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: adder operands are only driven while stepping digits
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.add_a   = 4'd0;
        bus.add_b   = 4'd0;
        bus.add_cin = 1'b0;
        case (r_state)
            c_add: begin
                bus.busy    = 1'b1;
                bus.add_a   = r_a[{r_idx, 2'b00} +: 4];
                bus.add_b   = r_b[{r_idx, 2'b00} +: 4];
                bus.add_cin = r_carry;
            end
            c_done: begin
                bus.done    = 1'b1;
            end
            default: begin
                bus.busy    = 1'b0;
            end
        endcase
    end

    assign bus.S     = r_s;
    assign bus.C_out = r_cout;
    assign bus.err   = r_err;

    // ------------------------------------------------------------------
    // Operand latch, digit stepping and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_carry <= bus.C_in;
                        r_idx   <= '0;
                        r_err   <= w_bad_operand;
                    end
                end
                c_add: begin
                    r_s[{r_idx, 2'b00} +: 4] <= bus.add_s;
                    r_carry                  <= bus.add_cout;
                    if (w_last_step) begin
                        // A rejected operand still runs the full sequence but
                        // reports a zero result; the later write wins here.
                        if (r_err) begin
                            r_s    <= '0;
                            r_cout <= 1'b0;
                        end else begin
                            r_cout <= bus.add_cout;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
